// File: rtl/rf_access_pkg.sv
// Shared opcodes, FSM state encoding and width defaults for the register-file access controller.
package rf_access_pkg;

    localparam int DW_DEF = 4;
    localparam int AW_DEF = 4;

    typedef logic [2:0] op_t;
    typedef logic [2:0] state_t;

    localparam op_t OP_NOP   = 3'd0;
    localparam op_t OP_WRITE = 3'd1;
    localparam op_t OP_READ  = 3'd2;
    localparam op_t OP_COPY  = 3'd3;
    localparam op_t OP_ADD   = 3'd4;
    localparam op_t OP_CLEAR = 3'd5;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_CAP  = 3'd2;
    localparam state_t ST_WR   = 3'd3;
    localparam state_t ST_CLR  = 3'd4;
    localparam state_t ST_RSP  = 3'd5;

    function automatic logic op_is_reserved(input op_t op);
        return op > OP_CLEAR;
    endfunction

endpackage

// File: rtl/rf_acc_alu.sv
// Combinational DW-bit adder with carry-out for the ADD command.
// Define RF_ACC_SAT_EN to saturate to all-ones on overflow instead of wrapping.
module rf_acc_alu #(
    parameter int DW = 4
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic          carry
);

    logic [DW:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b};
        carry = full[DW];
`ifdef RF_ACC_SAT_EN
        sum   = full[DW] ? {DW{1'b1}} : full[DW-1:0];
`else
        sum   = full[DW-1:0];
`endif
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// Valid/ready command initiator for the 16x4 register file; one response per command.
// Optional build macro RF_ACC_SAT_EN selects saturating ADD (see rf_acc_alu).
module rf_access_ctrl
    import rf_access_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [AW-1:0] cmd_rw,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_a,
    output logic [DW-1:0] rsp_b,
    output logic          rsp_carry,
    output logic          rsp_err,
    output logic          rf_rst,
    output logic          rf_we,
    output logic [AW-1:0] rf_ra,
    output logic [AW-1:0] rf_rb,
    output logic [AW-1:0] rf_rw,
    output logic [DW-1:0] rf_busw,
    input  logic [DW-1:0] rf_busa,
    input  logic [DW-1:0] rf_busb
);

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [AW-1:0] ra_q, ra_d, rb_q, rb_d, rw_q, rw_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
    logic          carry_q, carry_d;

    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
    logic          rsp_carry_q, rsp_carry_d, rsp_err_q, rsp_err_d;
    logic          rf_rst_q, rf_rst_d, rf_we_q, rf_we_d;
    logic [AW-1:0] rf_ra_q, rf_ra_d, rf_rb_q, rf_rb_d, rf_rw_q, rf_rw_d;
    logic [DW-1:0] rf_busw_q, rf_busw_d;

    logic          accept;
    logic [DW-1:0] alu_sum;
    logic          alu_carry;

    rf_acc_alu #(.DW(DW)) u_alu (
        .a     (rf_busa),
        .b     (rf_busb),
        .sum   (alu_sum),
        .carry (alu_carry)
    );

    // cmd_ready_q is high only in IDLE, so it doubles as the "may accept" qualifier.
    assign accept = cmd_valid && cmd_ready_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITE:                  state_d = ST_WR;
                        OP_READ, OP_COPY, OP_ADD:  state_d = ST_RD;
                        OP_CLEAR:                  state_d = ST_CLR;
                        default:                   state_d = ST_RSP;
                    endcase
                end
            end
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = (op_q == OP_READ) ? ST_RSP : ST_WR;
            ST_WR:   state_d = ST_RSP;
            ST_CLR:  state_d = ST_RSP;
            ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d   = op_q;
        ra_d   = ra_q;
        rb_d   = rb_q;
        rw_d   = rw_q;
        data_d = data_q;
        if (accept) begin
            op_d   = cmd_op;
            ra_d   = cmd_ra;
            rb_d   = cmd_rb;
            rw_d   = cmd_rw;
            data_d = cmd_data;
        end

        // Operand registers hold the result to be written back and reported (sum for ADD).
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        if (state_q == ST_CAP) begin
            opa_d   = (op_q == OP_ADD) ? alu_sum : rf_busa;
            opb_d   = rf_busb;
            carry_d = (op_q == OP_ADD) && alu_carry;
        end
    end

    // Outputs are registered from the next state so each one is valid for the whole state cycle.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RSP);
        rf_rst_d    = (state_d == ST_CLR);
        rf_we_d     = (state_d == ST_WR);
        rf_ra_d     = (state_d == ST_RD) ? ra_d : '0;
        rf_rb_d     = (state_d == ST_RD) ? rb_d : '0;
        rf_rw_d     = rf_we_d ? rw_d : '0;
        rf_busw_d   = '0;
        if (rf_we_d) rf_busw_d = (op_d == OP_WRITE) ? data_d : opa_d;

        rsp_a_d     = '0;
        rsp_b_d     = '0;
        rsp_carry_d = 1'b0;
        rsp_err_d   = 1'b0;
        if (rsp_valid_d) begin
            case (op_d)
                OP_READ: begin
                    rsp_a_d = opa_d;
                    rsp_b_d = opb_d;
                end
                OP_COPY: rsp_a_d = opa_d;
                OP_ADD: begin
                    rsp_a_d     = opa_d;
                    rsp_carry_d = carry_d;
                end
                default: rsp_err_d = op_is_reserved(op_d);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            ra_q        <= '0;
            rb_q        <= '0;
            rw_q        <= '0;
            data_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            carry_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rf_rst_q    <= 1'b1;
            rf_we_q     <= 1'b0;
            rf_ra_q     <= '0;
            rf_rb_q     <= '0;
            rf_rw_q     <= '0;
            rf_busw_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rw_q        <= rw_d;
            data_q      <= data_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            carry_q     <= carry_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
            rf_rst_q    <= rf_rst_d;
            rf_we_q     <= rf_we_d;
            rf_ra_q     <= rf_ra_d;
            rf_rb_q     <= rf_rb_d;
            rf_rw_q     <= rf_rw_d;
            rf_busw_q   <= rf_busw_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;
    assign rf_rst    = rf_rst_q;
    assign rf_we     = rf_we_q;
    assign rf_ra     = rf_ra_q;
    assign rf_rb     = rf_rb_q;
    assign rf_rw     = rf_rw_q;
    assign rf_busw   = rf_busw_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench for rf_access_ctrl: behavioural 16x4 register file, directed table,
// mid-operation reset sequence and randomized commands against an array-based reference model.
module tb_rf_access_ctrl;
    import rf_access_pkg::*;

`ifdef RF_ACC_SAT_EN
    localparam logic [3:0] ADD_SUM = 4'b1111;
    localparam bit         SAT     = 1'b1;
`else
    localparam logic [3:0] ADD_SUM = 4'b1001;
    localparam bit         SAT     = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_ra, cmd_rb, cmd_rw, cmd_data;
    logic [3:0] rsp_a, rsp_b;
    logic       rsp_carry, rsp_err, rf_rst, rf_we;
    logic [3:0] rf_ra, rf_rb, rf_rw, rf_busw, rf_busa, rf_busb;

    always #5 clk = ~clk;

    rf_access_ctrl #(.DW(4), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .rf_rst(rf_rst), .rf_we(rf_we), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rw(rf_rw),
        .rf_busw(rf_busw), .rf_busa(rf_busa), .rf_busb(rf_busb)
    );

    // Register file: sync clear, write on we, otherwise read with 1-cycle latency.
    logic [3:0] rf_mem [16];
    always @(posedge clk) begin
        if (rf_rst === 1'b1) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 4'd0;
        end else if (rf_we === 1'b1) begin
            rf_mem[rf_rw] <= rf_busw;
        end else begin
            rf_busa <= rf_mem[rf_ra];
            rf_busb <= rf_mem[rf_rb];
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [3:0] ra, rb, rw, data;
        int         hold;
        logic [3:0] exp_a, exp_b;
        logic       exp_carry, exp_err;
        int         exp_lat;
    } vec_t;

    int         n_vec = 0;
    int         n_mis = 0;
    logic [3:0] ref_mem [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] ra, rb, rw, data,
                                input int hold, input logic [3:0] ea, eb,
                                input logic ec, ee, input int lat);
        vec_t v;
        v.op = op; v.ra = ra; v.rb = rb; v.rw = rw; v.data = data; v.hold = hold;
        v.exp_a = ea; v.exp_b = eb; v.exp_carry = ec; v.exp_err = ee; v.exp_lat = lat;
        return v;
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        case (op)
            OP_WRITE, OP_CLEAR: return 2;
            OP_READ:            return 3;
            OP_COPY, OP_ADD:    return 4;
            default:            return 1;
        endcase
    endfunction

    // Reference: fill expected response fields from the reference register contents.
    function automatic vec_t model_expect(input vec_t v);
        vec_t r;
        int   s;
        r = v;
        r.exp_a = 4'd0; r.exp_b = 4'd0; r.exp_carry = 1'b0; r.exp_err = 1'b0;
        r.exp_lat = lat_of(v.op);
        case (v.op)
            OP_READ: begin r.exp_a = ref_mem[v.ra]; r.exp_b = ref_mem[v.rb]; end
            OP_COPY: r.exp_a = ref_mem[v.ra];
            OP_ADD: begin
                s = int'(ref_mem[v.ra]) + int'(ref_mem[v.rb]);
                r.exp_carry = (s >= 16);
                if (SAT && s >= 16) r.exp_a = 4'd15;
                else                r.exp_a = 4'(s % 16);
            end
            OP_NOP, OP_WRITE, OP_CLEAR: ;
            default: r.exp_err = 1'b1;
        endcase
        return r;
    endfunction

    function automatic void apply_ref(input vec_t v);
        case (v.op)
            OP_WRITE:        ref_mem[v.rw] = v.data;
            OP_COPY, OP_ADD: ref_mem[v.rw] = v.exp_a;
            OP_CLEAR:        for (int i = 0; i < 16; i++) ref_mem[i] = 4'd0;
            default: ;
        endcase
    endfunction

    // Issue one command from a negedge, measure latency, hold the response, then consume it.
    task automatic run_cmd(input int idx, input vec_t v);
        int         lat, we_cnt, rst_cnt, waited;
        logic [3:0] w_rw, w_val, exp_w;
        logic       exp_we, got;
        string      t;
        t = $sformatf("v%0d_op%0d", idx, v.op);
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({t, ".ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_ra = v.ra; cmd_rb = v.rb;
        cmd_rw = v.rw; cmd_data = v.data; rsp_ready = 1'b0;
        @(negedge clk);
        // Keep offering a conflicting WRITE while busy; it must not be consumed.
        cmd_op = OP_WRITE; cmd_rw = ~v.rw; cmd_data = ~v.data;
        lat = 1; we_cnt = 0; rst_cnt = 0; got = 1'b0; w_rw = 4'd0; w_val = 4'd0;
        while (!got && lat <= 12) begin
            if (rf_we === 1'b1) begin we_cnt++; w_rw = rf_rw; w_val = rf_busw; end
            if (rf_rst === 1'b1) rst_cnt++;
            if (rsp_valid === 1'b1) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({t, ".rsp_valid"}, got, 1'b1);
        if (got) begin
            check({t, ".latency"}, lat, v.exp_lat);
            check({t, ".rsp_a"}, rsp_a, v.exp_a);
            check({t, ".rsp_b"}, rsp_b, v.exp_b);
            check({t, ".rsp_carry"}, rsp_carry, v.exp_carry);
            check({t, ".rsp_err"}, rsp_err, v.exp_err);
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                if (rf_we === 1'b1) we_cnt++;
                if (rf_rst === 1'b1) rst_cnt++;
                check({t, ".hold_valid"}, rsp_valid, 1'b1);
                check({t, ".hold_a"}, rsp_a, v.exp_a);
                check({t, ".hold_b"}, rsp_b, v.exp_b);
                check({t, ".hold_ready"}, cmd_ready, 1'b0);
            end
            rsp_ready = 1'b1;
            cmd_valid = 1'b0;
            @(negedge clk);
            rsp_ready = 1'b0;
            if (rf_we === 1'b1) we_cnt++;
            check({t, ".post_valid"}, rsp_valid, 1'b0);
            check({t, ".post_ready"}, cmd_ready, 1'b1);
        end
        cmd_valid = 1'b0;
        exp_we = (v.op == OP_WRITE) || (v.op == OP_COPY) || (v.op == OP_ADD);
        check({t, ".we_cycles"}, we_cnt, exp_we ? 1 : 0);
        check({t, ".rst_cycles"}, rst_cnt, (v.op == OP_CLEAR) ? 1 : 0);
        if (exp_we) begin
            exp_w = (v.op == OP_WRITE) ? v.data : v.exp_a;
            check({t, ".wr_addr"}, w_rw, v.rw);
            check({t, ".wr_data"}, w_val, exp_w);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t tab[$];
        vec_t v;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_ra = 4'd0; cmd_rb = 4'd0;
        cmd_rw = 4'd0; cmd_data = 4'd0; rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 4'd0;

        //                op        ra  rb  rw  data     hold exp_a    exp_b    c     e     lat
        tab.push_back(mk(OP_READ,   5,  5,  0,  4'h0,    0,   4'h0,    4'h0,    1'b0, 1'b0, 3));
        tab.push_back(mk(OP_WRITE,  0,  0,  4,  4'b1010, 0,   4'h0,    4'h0,    1'b0, 1'b0, 2));
        tab.push_back(mk(OP_WRITE,  0,  0,  7,  4'b1111, 0,   4'h0,    4'h0,    1'b0, 1'b0, 2));
        tab.push_back(mk(OP_READ,   7,  4,  0,  4'h0,    0,   4'b1111, 4'b1010, 1'b0, 1'b0, 3));
        tab.push_back(mk(OP_ADD,    4,  7,  11, 4'h0,    1,   ADD_SUM, 4'h0,    1'b1, 1'b0, 4));
        tab.push_back(mk(OP_READ,   11, 11, 0,  4'h0,    0,   ADD_SUM, ADD_SUM, 1'b0, 1'b0, 3));
        tab.push_back(mk(OP_COPY,   11, 0,  11, 4'h0,    0,   ADD_SUM, 4'h0,    1'b0, 1'b0, 4));
        tab.push_back(mk(OP_COPY,   7,  0,  2,  4'h0,    3,   4'b1111, 4'h0,    1'b0, 1'b0, 4));
        tab.push_back(mk(OP_READ,   2,  7,  0,  4'h0,    0,   4'b1111, 4'b1111, 1'b0, 1'b0, 3));
        tab.push_back(mk(OP_WRITE,  0,  0,  1,  4'b0011, 0,   4'h0,    4'h0,    1'b0, 1'b0, 2));
        tab.push_back(mk(OP_ADD,    1,  1,  3,  4'h0,    0,   4'b0110, 4'h0,    1'b0, 1'b0, 4));
        tab.push_back(mk(OP_READ,   3,  11, 0,  4'h0,    0,   4'b0110, ADD_SUM, 1'b0, 1'b0, 3));
        tab.push_back(mk(OP_CLEAR,  0,  0,  0,  4'h0,    0,   4'h0,    4'h0,    1'b0, 1'b0, 2));
        tab.push_back(mk(OP_READ,   7,  4,  0,  4'h0,    0,   4'h0,    4'h0,    1'b0, 1'b0, 3));
        tab.push_back(mk(3'd6,      1,  2,  3,  4'hf,    0,   4'h0,    4'h0,    1'b0, 1'b1, 1));
        tab.push_back(mk(OP_NOP,    1,  2,  3,  4'hf,    0,   4'h0,    4'h0,    1'b0, 1'b0, 1));
        tab.push_back(mk(3'd7,      4,  5,  6,  4'h5,    2,   4'h0,    4'h0,    1'b0, 1'b1, 1));

        // Reset held for two edges.
        repeat (2) begin
            @(negedge clk);
            check("reset.rf_rst", rf_rst, 1'b1);
            check("reset.cmd_ready", cmd_ready, 1'b0);
            check("reset.rsp_valid", rsp_valid, 1'b0);
            check("reset.rf_we", rf_we, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("release.rf_rst", rf_rst, 1'b0);
        check("release.cmd_ready", cmd_ready, 1'b1);
        check("release.rsp_valid", rsp_valid, 1'b0);

        foreach (tab[i]) begin
            run_cmd(i, tab[i]);
            apply_ref(tab[i]);
        end

        // Reset asserted during the CAP cycle of an ADD: command is abandoned.
        run_cmd(100, model_expect(mk(OP_WRITE, 0, 0, 4, 4'b1001, 0, 0, 0, 0, 0, 0)));
        apply_ref(mk(OP_WRITE, 0, 0, 4, 4'b1001, 0, 0, 0, 0, 0, 0));
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_ra = 4'd4; cmd_rb = 4'd4; cmd_rw = 4'd9;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midrst.rf_we", rf_we, 1'b0);
            check("midrst.rsp_valid", rsp_valid, 1'b0);
            check("midrst.rf_rst", rf_rst, 1'b1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 4'd0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_after.rf_we", rf_we, 1'b0);
            check("midrst_after.rsp_valid", rsp_valid, 1'b0);
            check("midrst_after.rf_rst", rf_rst, 1'b0);
            check("midrst_after.cmd_ready", cmd_ready, 1'b1);
        end
        run_cmd(101, mk(OP_READ, 9, 4, 0, 4'h0, 0, 4'h0, 4'h0, 1'b0, 1'b0, 3));

        // Randomized commands against the reference model.
        for (int n = 0; n < 120; n++) begin
            v.op = 3'($urandom_range(0, 7));
            if (v.op == OP_CLEAR && $urandom_range(0, 3) != 0) v.op = OP_WRITE;
            v.ra = 4'($urandom_range(0, 15));
            v.rb = ($urandom_range(0, 4) == 0) ? v.ra : 4'($urandom_range(0, 15));
            v.rw = ($urandom_range(0, 4) == 0) ? v.ra : 4'($urandom_range(0, 15));
            v.data = 4'($urandom_range(0, 15));
            v.hold = $urandom_range(0, 2);
            v = model_expect(v);
            run_cmd(200 + n, v);
            apply_ref(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
